tx_frame_ctrl: RTL

Frame sequencer for the UART transmitter. It accepts one byte per send request and latches the byte and the frame configuration. It drives the latched byte and parity type to the Parity block and serialises start, data (LSB first), optional parity and 1 or 2 stop bits onto the line. Bit boundaries come from an external baud-rate tick.

---
 rtl/tx_frame_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl
//
// Frame sequencer for the UART transmitter. A send request latches one
// byte together with its frame configuration. The block then serialises
// the frame onto tx_out, advancing one bit per external baud tick:
// start bit, eight data bits LSB first, an optional parity bit, and one
// or two stop bits.
//
// The latched byte and parity type are exported so that an external
// Parity block can compute parity_bit combinationally from them.
//
// Ports
//   clock          in   system clock, rising edge active
//   reset_n        in   asynchronous active-low reset
//   send           in   transmit request, honoured only while idle
//   data_in[7:0]   in   byte to transmit
//   parity_type[1:0] in 01 odd, 10 even, 00/11 no parity bit
//   stop_bits      in   0 one stop bit, 1 two stop bits
//   baud_tick      in   single-cycle bit-boundary strobe
//   parity_bit     in   parity result for reg_data / parity_type_q
//   reg_data[7:0]  out  latched byte
//   parity_type_q[1:0] out latched parity type
//   tx_out         out  registered serial line, idle high
//   busy           out  high from acceptance until frame completion
//   done           out  one-clock pulse on frame completion
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line high, waiting for send
// SYNC    | frame accepted, waiting for a tick to begin the start bit
// START   | start bit (0) on the line
// DATA    | data bit bit_idx_q on the line
// PARITY  | parity bit on the line
// STOP1   | first stop bit on the line
// STOP2   | second stop bit on the line

module tx_frame_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       baud_tick,
  input  logic       parity_bit,
  output logic [7:0] reg_data,
  output logic [1:0] parity_type_q,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP1  = 3'd5,
    ST_STOP2  = 3'd6
  } state_t;

  state_t              state_q;
  logic [2:0]          bit_idx_q;
  logic [DATA_W-1:0]   reg_data_q;
  logic [1:0]          ptype_q;
  logic                stop2_q;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;

  logic [2:0]          bit_nxt;
  logic                par_en;

  assign bit_nxt = bit_idx_q + 3'd1;
  // Exactly one of the two type bits set selects odd (01) or even (10).
  assign par_en  = ptype_q[1] ^ ptype_q[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= 3'd0;
      reg_data_q <= '0;
      ptype_q    <= 2'b00;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the final stop edge raises it.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A tick coincident with acceptance is deliberately not used:
          // SYNC waits for the next one so the start bit is a full period.
          if (send && !busy_q) begin
            reg_data_q <= data_in;
            ptype_q    <= parity_type;
            stop2_q    <= stop_bits;
            bit_idx_q  <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            tx_q      <= reg_data_q[0];
            bit_idx_q <= 3'd0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx_q != 3'd7) begin
              bit_idx_q <= bit_nxt;
              tx_q      <= reg_data_q[bit_nxt];
            end else if (par_en) begin
              // reg_data/ptype have been stable since acceptance, so the
              // external parity result is settled here.
              tx_q    <= parity_bit;
              state_q <= ST_PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (baud_tick) begin
            tx_q <= 1'b1;
            if (stop2_q) begin
              state_q <= ST_STOP2;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_data      = reg_data_q;
  assign parity_type_q = ptype_q;
  assign tx_out        = tx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
